// File: rtl/ysyx_220053_ifu_queue_if.sv
// Fetch-side bundle of the IFU queue: memory request/response, redirect and instruction output.
// The master modport is the IFU itself; slave is its environment (memory, pipeline).
interface ysyx_220053_ifu_queue_if #(
    parameter int unsigned XLEN = 64
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            resp_valid;
    logic [31:0]     resp_data;
    logic            resp_err;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_pc;
    logic [31:0]     inst_data;
    logic            inst_err;

    modport master (
        output req_valid, req_addr, inst_valid, inst_pc, inst_data, inst_err,
        input  req_ready, resp_valid, resp_data, resp_err, redirect_valid, redirect_pc,
               inst_ready
    );

    modport slave (
        input  req_valid, req_addr, inst_valid, inst_pc, inst_data, inst_err,
        output req_ready, resp_valid, resp_data, resp_err, redirect_valid, redirect_pc,
               inst_ready
    );
endinterface

// File: rtl/ysyx_220053_ifu_queue.sv
// Instruction fetch unit with one outstanding memory request and a small fetch queue.
// Redirects flush the queue and kill any response still owed to the old stream.
module ysyx_220053_ifu_queue #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'('h8000_0000),
    parameter int unsigned     FQ_DEPTH = 4
) (
    input logic                      clk,
    input logic                      rst,
    ysyx_220053_ifu_queue_if.master  ifu
);
    localparam int unsigned PtrW = $clog2(FQ_DEPTH);
    localparam int unsigned CntW = $clog2(FQ_DEPTH + 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(FQ_DEPTH);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] HALT  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            kill_q, kill_d;
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [XLEN-1:0] fq_pc   [FQ_DEPTH];
    logic [31:0]     fq_data [FQ_DEPTH];
    logic            fq_err  [FQ_DEPTH];

    logic req_fire;
    logic resp_in;
    logic push;
    logic pop;

    // In FETCH nothing is in flight, so the occupancy bound reduces to the queue count.
    assign ifu.req_valid  = !rst && (state_q == FETCH) && (cnt_q < DepthCnt);
    assign ifu.req_addr   = fetch_pc_q;
    assign ifu.inst_valid = (cnt_q != '0);
    assign ifu.inst_pc    = fq_pc[head_q];
    assign ifu.inst_data  = fq_data[head_q];
    assign ifu.inst_err   = fq_err[head_q];

    assign req_fire = ifu.req_valid && ifu.req_ready;
    assign resp_in  = (state_q == WAIT) && ifu.resp_valid;
    assign push     = resp_in && !kill_q && !ifu.redirect_valid;
    assign pop      = ifu.inst_valid && ifu.inst_ready;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        kill_d     = kill_q;

        case (state_q)
            FETCH: begin
                if (req_fire) begin
                    fetch_pc_d = fetch_pc_q + XLEN'(4);
                    req_pc_d   = fetch_pc_q;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (ifu.resp_valid) begin
                    kill_d  = 1'b0;
                    state_d = (kill_q || !ifu.resp_err) ? FETCH : HALT;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // A redirect wins over everything; it only has to remember whether an old
        // request is still owed a response that must be thrown away.
        if (ifu.redirect_valid) begin
            fetch_pc_d = {ifu.redirect_pc[XLEN-1:2], 2'b00};
            kill_d     = req_fire || ((state_q == WAIT) && !ifu.resp_valid);
            state_d    = kill_d ? WAIT : FETCH;
        end
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (ifu.redirect_valid) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + PtrW'(1);
            end
            if (pop) begin
                head_d = head_q + PtrW'(1);
            end
            if (push && !pop) begin
                cnt_d = cnt_q + CntW'(1);
            end else if (pop && !push) begin
                cnt_d = cnt_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            kill_q     <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            kill_q     <= kill_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
        end
    end

    // Storage needs no reset: an entry is only visible once cnt_q covers it.
    always_ff @(posedge clk) begin
        if (push) begin
            fq_pc[tail_q]   <= req_pc_q;
            fq_data[tail_q] <= ifu.resp_data;
            fq_err[tail_q]  <= ifu.resp_err;
        end
    end
endmodule

// File: tb/tb_ysyx_220053_ifu_queue.sv
// Randomized bench for the IFU queue against a transaction-level model of the fetch stream.
module tb_ysyx_220053_ifu_queue;
    localparam int unsigned XLEN  = 64;
    localparam int unsigned DEPTH = 4;
    localparam logic [63:0] RPC   = 64'h8000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_220053_ifu_queue_if #(.XLEN(XLEN)) bus ();

    ysyx_220053_ifu_queue #(
        .XLEN    (XLEN),
        .RESET_PC(RPC),
        .FQ_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ifu(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        logic [63:0] pc;
        logic [31:0] data;
        logic        err;
    } entry_t;

    // Model: delivered-but-unconsumed instructions, next fetch address, the request owed
    // a response (and whether it has been orphaned by a redirect), and the fault stop.
    entry_t      exp_q[$];
    logic [63:0] m_pc;
    logic [63:0] m_pend_pc;
    bit          m_pend;
    bit          m_dead;
    bit          m_halt;

    int p_req_ready, p_inst_ready, p_resp, p_err, p_redirect, p_spur;
    bit          f_redir;
    logic [63:0] f_rpc;

    function automatic bit chance(input int pct);
        return ($urandom % 100) < pct;
    endfunction

    function automatic bit model_req_valid();
        return !m_pend && !m_halt && (exp_q.size() < DEPTH);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_pc = RPC;
        m_pend_pc = RPC;
        m_pend = 0;
        m_dead = 0;
        m_halt = 0;
    endtask

    task automatic drive_inputs();
        logic [63:0] pick;
        bus.req_ready  = chance(p_req_ready);
        bus.inst_ready = chance(p_inst_ready);
        bus.resp_valid = m_pend ? chance(p_resp) : chance(p_spur);
        bus.resp_data  = $urandom;
        bus.resp_err   = chance(p_err);
        case ($urandom % 4)
            0: pick = 64'h0000_0000_8000_1002;
            1: pick = 64'h0000_0000_8000_0100;
            2: pick = 64'hFFFF_FFFF_FFFF_FFFC;
            default: pick = {$urandom, $urandom};
        endcase
        bus.redirect_valid = chance(p_redirect);
        bus.redirect_pc    = pick;
        if (f_redir) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = f_rpc;
            f_redir            = 0;
        end
    endtask

    task automatic check_outputs();
        bit rv;
        rv = model_req_valid();
        check_val("req_valid", 64'(bus.req_valid), 64'(rv));
        if (rv) check_val("req_addr", bus.req_addr, m_pc);
        check_val("req_addr_align", 64'(bus.req_addr[1:0]), 64'd0);
        check_val("inst_valid", 64'(bus.inst_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check_val("inst_pc", bus.inst_pc, exp_q[0].pc);
            check_val("inst_data", 64'(bus.inst_data), 64'(exp_q[0].data));
            check_val("inst_err", 64'(bus.inst_err), 64'(exp_q[0].err));
        end
    endtask

    task automatic model_step();
        bit hs, pop, rsp;
        entry_t e;
        hs  = model_req_valid() && bus.req_ready;
        pop = (exp_q.size() != 0) && bus.inst_ready;
        rsp = m_pend && bus.resp_valid;
        if (bus.redirect_valid) begin
            exp_q.delete();
            m_pc   = {bus.redirect_pc[63:2], 2'b00};
            m_halt = 0;
            if (hs) begin
                m_pend = 1;
                m_dead = 1;
            end else if (rsp) begin
                m_pend = 0;
                m_dead = 0;
            end else if (m_pend) begin
                m_dead = 1;
            end
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (rsp) begin
                if (!m_dead) begin
                    e.pc   = m_pend_pc;
                    e.data = bus.resp_data;
                    e.err  = bus.resp_err;
                    exp_q.push_back(e);
                    if (bus.resp_err) m_halt = 1;
                end
                m_pend = 0;
                m_dead = 0;
            end
            if (hs) begin
                m_pend    = 1;
                m_dead    = 0;
                m_pend_pc = m_pc;
                m_pc      = m_pc + 64'd4;
            end
        end
    endtask

    // Entered and left at posedge + 1.
    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive_inputs();
            @(negedge clk);
            check_outputs();
            model_step();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.resp_valid = 1'b1;
        bus.redirect_valid = 1'b0;
        #1;
        check_val("rst_req_valid", 64'(bus.req_valid), 64'd0);
        check_val("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
        @(posedge clk);
        #1;
        check_val("rst_req_valid_hold", 64'(bus.req_valid), 64'd0);
        check_val("rst_req_addr", bus.req_addr, RPC);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic set_knobs(input int rr, input int ir, input int rs, input int er,
                             input int rd, input int sp);
        p_req_ready = rr; p_inst_ready = ir; p_resp = rs;
        p_err = er; p_redirect = rd; p_spur = sp;
    endtask

    initial begin
        f_redir = 0;
        f_rpc = '0;
        bus.req_ready = 0; bus.inst_ready = 0; bus.resp_valid = 0;
        bus.resp_data = '0; bus.resp_err = 0; bus.redirect_valid = 0; bus.redirect_pc = '0;
        set_knobs(100, 100, 100, 0, 0, 0);
        @(posedge clk);
        #1;
        apply_reset();

        // Straight-line fetch with single-cycle memory.
        cycles(30);
        // Consumer stalls long enough to fill the queue, then drains.
        set_knobs(100, 0, 100, 0, 0, 0);
        cycles(20);
        set_knobs(100, 100, 100, 0, 0, 0);
        cycles(10);

        // Redirect while the request is waiting on memory.
        set_knobs(100, 100, 0, 0, 0, 0);
        cycles(2);
        f_redir = 1; f_rpc = 64'h0000_0000_8000_1002;
        cycles(3);
        set_knobs(100, 100, 100, 0, 0, 0);
        cycles(10);

        // Access fault stops fetch until a redirect.
        set_knobs(100, 100, 100, 100, 0, 0);
        cycles(8);
        set_knobs(100, 100, 100, 0, 0, 30);
        cycles(4);
        f_redir = 1; f_rpc = 64'h0000_0000_8000_0100;
        cycles(10);

        // Memory refusing requests, then a redirect during the stall.
        set_knobs(0, 100, 100, 0, 0, 0);
        cycles(5);
        f_redir = 1; f_rpc = 64'h0000_0000_8000_2000;
        cycles(3);

        // Address wrap at the top of the space.
        set_knobs(100, 100, 100, 0, 0, 0);
        f_redir = 1; f_rpc = 64'hFFFF_FFFF_FFFF_FFFC;
        cycles(6);

        // Random traffic, a reset in the middle of it, then more traffic.
        set_knobs(60, 50, 40, 5, 4, 10);
        cycles(1500);
        set_knobs(100, 0, 0, 0, 0, 0);
        cycles(12);
        apply_reset();
        set_knobs(70, 60, 50, 6, 5, 10);
        cycles(800);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ysyx_220053_ifu_queue.md
YSYX_220053_IFU_QUEUE -- requirements
Module: ysyx_220053_ifu_queue

Interface
REQ-001 Parameter XLEN, default 64, address and PC width in bits.
REQ-002 Parameter RESET_PC, default 64'h80000000, first fetch address after reset.
REQ-003 Parameter FQ_DEPTH, default 4, fetch-queue entries; power of two, >=2.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  output  1  fetch request to instruction memory.
REQ-007 req_ready  input  1  memory accepts request; handshake = req_valid & req_ready.
REQ-008 req_addr  output  XLEN  fetch address, bits [1:0] always 0.
REQ-009 resp_valid  input  1  response for the single outstanding request; no backpressure.
REQ-010 resp_data  input  32  instruction word.
REQ-011 resp_err  input  1  access fault for this response.
REQ-012 redirect_valid  input  1  pipeline redirect (branch/jump/exception).
REQ-013 redirect_pc  input  XLEN  new fetch PC; bits [1:0] ignored and treated as 0.
REQ-014 inst_valid  output  1  queue head valid.
REQ-015 inst_ready  input  1  consumer pops head; pop = inst_valid & inst_ready.
REQ-016 inst_pc  output  XLEN  PC of head entry.
REQ-017 inst_data  output  32  instruction of head entry.
REQ-018 inst_err  output  1  access fault flag of head entry.

Function
REQ-019 States: FETCH, WAIT, HALT; plus internal fetch_pc register and kill flag.
REQ-020 FETCH: req_valid = 1 iff (queue count + in-flight) < FQ_DEPTH; req_addr = fetch_pc.
REQ-021 FETCH and request handshake: fetch_pc <= fetch_pc + 4 (mod 2^XLEN, wrap silently), go WAIT.
REQ-022 At most one request in flight; req_valid = 0 in WAIT and HALT.
REQ-023 WAIT and resp_valid, kill = 0: push {pc, resp_data, resp_err} at tail; go FETCH if resp_err = 0, else HALT.
REQ-024 WAIT and resp_valid, kill = 1: discard response, clear kill, go FETCH.
REQ-025 Response latency unbounded; resp_valid in FETCH or HALT is ignored.
REQ-026 HALT: no requests issued until redirect; queue still drains normally.
REQ-027 Redirect (any state): queue flushed next cycle, fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
REQ-028 Redirect in FETCH without handshake: go/stay FETCH; req_addr shows new PC next cycle (unaccepted request withdrawn).
REQ-029 Redirect in HALT: go FETCH.
REQ-030 Redirect in WAIT, or same cycle as FETCH handshake: kill <= 1, state WAIT; response for old request dropped.
REQ-031 Redirect same cycle as resp_valid in WAIT: response dropped, go FETCH, kill stays 0.
REQ-032 Redirect same cycle as pop: consumer receives current head; queue empty next cycle.
REQ-033 Redirect overrides fetch_pc increment of same cycle.
REQ-034 Push and pop same cycle: both take effect, count unchanged; push into full queue never occurs by REQ-020.
REQ-035 Empty queue: inst_valid = 0; inst_pc/inst_data/inst_err don't-care; no bypass from response to output (min. 1 cycle response-to-inst_valid).
REQ-036 Queue pointers log2(FQ_DEPTH) bits, wrap naturally; count FQ_DEPTH+1 values.
REQ-037 Outputs driven from registers or from registered state only; no combinational path from resp_* to inst_*.

Reset
REQ-038 While rst = 1: state FETCH, fetch_pc = RESET_PC, kill = 0, queue empty, req_valid = 0, inst_valid = 0.
REQ-039 First cycle after rst deasserts: req_valid = 1, req_addr = RESET_PC.
REQ-040 rst asserted mid-operation (WAIT, kill set, queue full): all state returns to REQ-038 immediately; later stale resp_valid ignored.

Verification
REQ-041 Reset release, req_ready = 1, 1-cycle responses, inst_ready = 1 -> inst_pc sequence 0x80000000, 0x80000004, 0x80000008, data matches memory.
REQ-042 inst_ready = 0 for 20 cycles -> exactly FQ_DEPTH (4) entries queued, req_valid = 0, no entry lost after inst_ready = 1.
REQ-043 Redirect to 0x80001002 while request in WAIT -> old response dropped, next inst_pc = 0x80001000, queue empty in between.
REQ-044 resp_err = 1 at 0x80000008 -> entry with inst_err = 1 delivered, no further req_valid until redirect to 0x80000100, then fetch resumes there.
REQ-045 req_ready held 0 for 5 cycles -> req_addr stable at 0x80000000; redirect during stall -> req_addr becomes redirect target next cycle.
REQ-046 fetch_pc = 0xFFFFFFFFFFFFFFFC accepted -> next req_addr = 0x0000000000000000.
